// File: rtl/sub_nibble_seq.sv
// ---------------------------------------------------------------------------
// sub_nibble_seq
//   Sequential WIDTH-bit subtractor: computes i_a - i_b - i_bin one 4-bit
//   nibble per clock, least-significant nibble first. A single registered
//   borrow links consecutive nibbles. Each nibble is produced by
//   sub_nibble_slice, the borrow-form twin of the 4-bit carry-lookahead
//   adder slice: a + ~b + ~borrow, where borrow out = ~carry out.
//
//   Ports
//     i_clk, i_rstn     clock (rising edge), async active-low reset
//     i_valid, o_ready  operand handshake (o_ready = state IDLE)
//     i_a, i_b, i_bin   minuend, subtrahend, borrow in
//     o_valid, i_ready  result handshake (o_valid = state DONE)
//     o_d               difference mod 2^WIDTH
//     o_bout            borrow out of MSB (unsigned a < b + bin)
//     o_ovf             two's-complement overflow
//     o_zero            o_d == 0
//
//   Latency is N = WIDTH/4 cycles from accept to o_valid. Result outputs
//   hold after the result handshake until the next accept.
// ---------------------------------------------------------------------------

// 4-bit borrow-form lookahead slice: d = a - b - bin.
// Ports: a, b (nibbles), bin (borrow in), d (difference), bout (borrow out).
module sub_nibble_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       bin,
    output logic [3:0] d,
    output logic       bout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    // Subtraction as addition of ~b with carry-in ~bin.
    assign g = a & ~b;
    assign p = a ^ ~b;

    assign c[0] = ~bin;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign d    = p ^ c[3:0];
    assign bout = ~c[4];
endmodule

module sub_nibble_seq #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_bin,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_d,
    output logic             o_bout,
    output logic             o_ovf,
    output logic             o_zero
);
    localparam int N  = WIDTH / 4;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
            $error("sub_nibble_seq: WIDTH must be a multiple of 4 and >= 8");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             borrow_q;
    logic [KW-1:0]    k_q;

    logic [KW+1:0]    base;
    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [3:0]       nib_d;
    logic             nib_bout;
    logic [WIDTH-1:0] d_next;

    // Bit offset of the current nibble.
    assign base  = {k_q, 2'b00};
    assign a_nib = a_q[base +: 4];
    assign b_nib = b_q[base +: 4];

    sub_nibble_slice u_slice (
        .a    (a_nib),
        .b    (b_nib),
        .bin  (borrow_q),
        .d    (nib_d),
        .bout (nib_bout)
    );

    // o_d with the current nibble merged in; on the last step this is the
    // fully assembled difference, so zero/overflow flags derive from it.
    always_comb begin
        d_next             = o_d;
        d_next[base +: 4]  = nib_d;
    end

    assign o_ready = (state == IDLE);
    assign o_valid = (state == DONE);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            k_q      <= '0;
            o_d      <= '0;
            o_bout   <= 1'b0;
            o_ovf    <= 1'b0;
            o_zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        a_q      <= i_a;
                        b_q      <= i_b;
                        borrow_q <= i_bin;
                        k_q      <= '0;
                        o_d      <= '0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    o_d      <= d_next;
                    borrow_q <= nib_bout;
                    if (k_q == K_LAST) begin
                        o_bout <= nib_bout;
                        o_ovf  <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                                  (d_next[WIDTH-1] != a_q[WIDTH-1]);
                        o_zero <= (d_next == '0);
                        state  <= DONE;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                DONE: begin
                    if (i_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sub_nibble_seq.sv
// Self-checking bench for sub_nibble_seq (WIDTH = 32): directed cases,
// backpressure, async reset mid-run, then randomized transactions against
// an arithmetic reference model.
module tb_sub_nibble_seq;
    localparam int W = 32;

    logic          i_clk = 1'b0;
    logic          i_rstn = 1'b0;
    logic          i_valid = 1'b0;
    logic          o_ready;
    logic [W-1:0]  i_a = '0;
    logic [W-1:0]  i_b = '0;
    logic          i_bin = 1'b0;
    logic          o_valid;
    logic          i_ready = 1'b0;
    logic [W-1:0]  o_d;
    logic          o_bout;
    logic          o_ovf;
    logic          o_zero;

    int total = 0;
    int bad   = 0;

    always #5 i_clk = ~i_clk;

    sub_nibble_seq #(.WIDTH(W)) dut (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_bin   (i_bin),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_d     (o_d),
        .o_bout  (o_bout),
        .o_ovf   (o_ovf),
        .o_zero  (o_zero)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain wide arithmetic, unsigned for borrow, signed for overflow.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                         output logic [W-1:0] d, output logic bout,
                         output logic ovf, output logic zero);
        longint ur;
        longint sr;
        ur   = longint'(a) - longint'(b) - longint'(bin);
        sr   = longint'($signed(a)) - longint'($signed(b)) - longint'(bin);
        d    = ur[W-1:0];
        bout = (ur < 0);
        ovf  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        zero = (d == '0);
    endtask

    // Present operands and wait for the accept edge; returns #1 after it.
    task automatic start(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        int cyc;
        @(negedge i_clk);
        i_a = a; i_b = b; i_bin = bin; i_valid = 1'b1;
        cyc = 0;
        while (!o_ready && cyc < 50) begin
            @(negedge i_clk);
            cyc++;
        end
        if (!o_ready) chk("accept_timeout", 0, 1);
        @(posedge i_clk);
        #1;
        // Scrambled operands after accept must be ignored.
        i_valid = 1'b0; i_a = $urandom; i_b = $urandom; i_bin = 1'($urandom);
    endtask

    task automatic wait_valid(input string tag);
        int cyc;
        cyc = 0;
        while (!o_valid && cyc < 50) begin
            @(posedge i_clk);
            #1;
            cyc++;
        end
        chk({tag, "_latency"}, 64'(cyc), 64'd8);
    endtask

    task automatic check_res(input string tag, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic bin);
        logic [W-1:0] d;
        logic bo, ov, z;
        model(a, b, bin, d, bo, ov, z);
        chk({tag, "_d"},    64'(o_d),    64'(d));
        chk({tag, "_bout"}, 64'(o_bout), 64'(bo));
        chk({tag, "_ovf"},  64'(o_ovf),  64'(ov));
        chk({tag, "_zero"}, 64'(o_zero), 64'(z));
    endtask

    // Result handshake; outputs must hold afterwards.
    task automatic finish_res(input string tag, input int stall);
        logic [W-1:0] held;
        held = o_d;
        for (int i = 0; i < stall; i++) begin
            @(posedge i_clk);
            #1;
            chk({tag, "_stall_valid"}, 64'(o_valid), 64'd1);
        end
        @(negedge i_clk);
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        chk({tag, "_post_valid"}, 64'(o_valid), 64'd0);
        chk({tag, "_post_ready"}, 64'(o_ready), 64'd1);
        chk({tag, "_post_hold"},  64'(o_d),     64'(held));
        @(negedge i_clk);
        i_ready = 1'b0;
    endtask

    task automatic txn(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic bin, input int stall);
        start(a, b, bin);
        wait_valid(tag);
        check_res(tag, a, b, bin);
        finish_res(tag, stall);
    endtask

    initial begin
        logic [W-1:0] xa, xb, held, ed;
        logic eb, eo, ez;

        // Reset state
        #12;
        chk("rst_ready", 64'(o_ready), 64'd1);
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_d",     64'(o_d),     64'd0);
        chk("rst_flags", 64'({o_bout, o_ovf, o_zero}), 64'd0);
        @(negedge i_clk);
        i_rstn = 1'b1;

        txn("t5m3",   32'h0000_0005, 32'h0000_0003, 1'b0, 0);
        txn("t0m1",   32'h0000_0000, 32'h0000_0001, 1'b0, 1);
        txn("tovf",   32'h8000_0000, 32'h0000_0001, 1'b0, 0);
        txn("tzero",  32'h1234_5678, 32'h1234_5677, 1'b1, 2);

        // Backpressure: DONE held while new operands are offered.
        start(32'h0000_00A0, 32'h0000_0001, 1'b0);
        wait_valid("bp");
        check_res("bp", 32'h0000_00A0, 32'h0000_0001, 1'b0);
        held = o_d;
        xa = 32'hDEAD_BEEF; xb = 32'h0BAD_F00D;
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clk);
            i_valid = 1'b1; i_a = xa; i_b = xb; i_bin = 1'b1;
            @(posedge i_clk);
            #1;
            chk("bp_valid", 64'(o_valid), 64'd1);
            chk("bp_ready", 64'(o_ready), 64'd0);
            chk("bp_hold",  64'(o_d),     64'(held));
        end
        @(negedge i_clk);
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        chk("bp_idle_ready", 64'(o_ready), 64'd1);
        chk("bp_idle_valid", 64'(o_valid), 64'd0);
        i_ready = 1'b0;
        start(xa, xb, 1'b1);
        wait_valid("bp_new");
        check_res("bp_new", xa, xb, 1'b1);
        finish_res("bp_new", 0);

        // Async reset after nibble 3 is written (edge E+4).
        start(32'h0000_0000, 32'h0000_0001, 1'b0);
        for (int i = 0; i < 4; i++) @(posedge i_clk);
        #1;
        chk("mid_partial", 64'(o_d), 64'h0000_FFFF);
        #2;
        i_rstn = 1'b0;
        #1;
        chk("mid_rst_d",     64'(o_d),     64'd0);
        chk("mid_rst_ready", 64'(o_ready), 64'd1);
        chk("mid_rst_valid", 64'(o_valid), 64'd0);
        chk("mid_rst_flags", 64'({o_bout, o_ovf, o_zero}), 64'd0);
        @(negedge i_clk);
        i_rstn = 1'b1;
        txn("after_rst", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0);
        model(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, ed, eb, eo, ez);
        chk("after_rst_spec_d", 64'(o_d), 64'hFFFF_FFFF);
        chk("after_rst_spec_b", 64'(o_bout), 64'd1);

        // Randomized transactions.
        for (int n = 0; n < 25; n++) begin
            logic [W-1:0] ra, rb;
            logic rbin;
            ra = $urandom; rb = $urandom; rbin = 1'($urandom);
            if (n % 5 == 0) rb = ra;
            if (n % 7 == 0) ra = {1'b1, 31'($urandom)};
            txn("rand", ra, rb, rbin, int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
